// File: rtl/scoreboard_regfile.sv
// rtl/scoreboard_regfile.sv - multi-read register file with pending-writeback scoreboard and sweep-clear FSM
//
// Ports:
//   clk                          rising-edge clock
//   rst                          asynchronous active-low reset
//   rd_addr  [NUM_RD*ADDR_W]     read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data  [NUM_RD*DATA_W]     read data, port i at [i*DATA_W +: DATA_W]
//   rd_busy  [NUM_RD]            per-port pending-writeback flag
//   wr0_en/wr0_addr/wr0_data     ALU writeback port
//   wr1_en/wr1_addr/wr1_data     load writeback port (wins over wr0 on same address)
//   iss_en/iss_addr              issue: mark destination register pending
//   clr_req                      start a full register sweep-clear
//   clr_busy                     sweep in progress (SWEEP or DONE)
//   clr_done                     one-cycle pulse when the sweep completes
module scoreboard_regfile #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr0_en,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic                     clr_req,
    output logic                     clr_busy,
    output logic                     clr_done
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  idx, idx_nxt;
    logic [DATA_W-1:0]  regs [DEPTH];
    logic [DEPTH-1:0]   busy;
    logic               idle;
    logic               w0_ok, w1_ok, iss_ok;

    // Every write/issue qualifier already folds in IDLE and the zero-register rule,
    // so the bypass and busy-mask logic below can use them directly.
    assign idle   = (state == IDLE);
    assign w0_ok  = idle && wr0_en && (wr0_addr != '0);
    assign w1_ok  = idle && wr1_en && (wr1_addr != '0);
    assign iss_ok = idle && iss_en && (iss_addr != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            idx   <= ADDR_W'(1);
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        clr_busy  = 1'b0;
        clr_done  = 1'b0;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt = SWEEP;
                    idx_nxt   = ADDR_W'(1);
                end
            end
            SWEEP: begin
                clr_busy = 1'b1;
                idx_nxt  = idx + ADDR_W'(1);
                if (idx == LAST_IDX) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                clr_busy  = 1'b1;
                clr_done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Statement order encodes the priorities: wr1 after wr0 so wr1 wins a shared
    // address, and the issue set after the write clears so issue+write ends busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else if (state == SWEEP) begin
            regs[idx] <= '0;
            busy[idx] <= 1'b0;
        end else begin
            if (w0_ok) begin
                regs[wr0_addr] <= wr0_data;
                busy[wr0_addr] <= 1'b0;
            end
            if (w1_ok) begin
                regs[wr1_addr] <= wr1_data;
                busy[wr1_addr] <= 1'b0;
            end
            if (iss_ok) begin
                busy[iss_addr] <= 1'b1;
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              hit0, hit1;

        assign addr = rd_addr[p*ADDR_W +: ADDR_W];
        assign hit0 = w0_ok && (wr0_addr == addr);
        assign hit1 = w1_ok && (wr1_addr == addr);

        assign rd_data[p*DATA_W +: DATA_W] = (addr == '0) ? '0       :
                                             hit1         ? wr1_data :
                                             hit0         ? wr0_data :
                                                            regs[addr];
        // busy[0] is never set, so address 0 needs no special case here.
        assign rd_busy[p] = busy[addr] && !(hit0 || hit1);
    end

endmodule
